// File: rtl/uart_pkg.sv
// Definitions shared by the variable-rate UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int DATA_BITS   = 8;
  localparam int CLKS_115200 = 217;
  localparam int CLKS_9600   = 2604;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit clock counter: latches the period on load, counts 0..P-1 while run
// is high and strobes bit_end on the last count of each bit.
module uart_bit_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] period,
  output logic         bit_end
);

  logic [W-1:0] period_q;
  logic [W-1:0] count;

  assign bit_end = run && (count == (period_q - W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      count    <= '0;
    end else if (load) begin
      period_q <= period;
      count    <= '0;
    end else if (run) begin
      count <= bit_end ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/uart_variable_tx.sv
// Variable-rate 8N1 UART transmitter; period in clocks per bit is latched per frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_variable_tx #(
  parameter int CLKS_PER_BIT_W = 20,
  parameter int DATA_BITS      = uart_pkg::DATA_BITS
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [CLKS_PER_BIT_W-1:0] i_Period,
  input  logic                      i_TX_DV,
  input  logic [DATA_BITS-1:0]      i_TX_Byte,
  output logic                      o_UART_TX,
  output logic                      o_TX_Active,
  output logic                      o_TX_Done
);
  import uart_pkg::*;

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] byte_q, byte_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 tx_q, tx_n;
  logic                 active_q, active_n;
  logic                 done_q, done_n;
  logic                 accept;
  logic                 bit_end;

  // The last stop-bit cycle also accepts a request so frames can abut with no idle gap.
  assign accept = i_TX_DV && (i_Period != '0) &&
                  ((state == IDLE) || ((state == STOP) && bit_end));

  uart_bit_timer #(.W(CLKS_PER_BIT_W)) u_timer (
    .clk     (i_Clk),
    .rst     (i_Reset),
    .load    (accept),
    .run     (state != IDLE),
    .period  (i_Period),
    .bit_end (bit_end)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      byte_q   <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_q   <= byte_n;
      bit_idx  <= bit_idx_n;
      tx_q     <= tx_n;
      active_q <= active_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    byte_n    = byte_q;
    bit_idx_n = bit_idx;
    tx_n      = tx_q;
    active_n  = active_q;
    done_n    = 1'b0;
    case (state)
      START: if (bit_end) begin
        state_n   = DATA;
        bit_idx_n = '0;
        tx_n      = byte_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          tx_n    = ^byte_q;
`else
          state_n = STOP;
          tx_n    = 1'b1;
`endif
        end else begin
          bit_idx_n = bit_idx + 1'b1;
          tx_n      = byte_q[bit_idx + 1'b1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        state_n  = IDLE;
        tx_n     = 1'b1;
        active_n = 1'b0;
        done_n   = 1'b1;
      end
      default: ;
    endcase
    if (accept) begin
      state_n   = START;
      byte_n    = i_TX_Byte;
      bit_idx_n = '0;
      tx_n      = 1'b0;
      active_n  = 1'b1;
    end
  end

  assign o_UART_TX   = tx_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_variable_tx.sv
// Self-checking bench for uart_variable_tx: a frame-level reference model
// predicts line/active/done every cycle, plus directed timing checks.
module tb_uart_variable_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] period;
  logic        dv;
  logic [7:0]  tx_byte;
  logic        line, active, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state: one frame in flight at most
  bit         m_busy = 1'b0;
  int         m_k, m_p;
  logic [7:0] m_b;
  int         m_done_cyc = -1;
  logic [7:0] rx_bits;

  uart_variable_tx dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Period    (period),
    .i_TX_DV     (dv),
    .i_TX_Byte   (tx_byte),
    .o_UART_TX   (line),
    .o_TX_Active (active),
    .o_TX_Done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame position i: 0 start, 1..8 data LSB first, optional parity, then stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    int off;
    int idx;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy     = 1'b0;
      m_done_cyc = -1;
    end else begin
      if (m_busy && cyc == m_k + FRAME * m_p) begin
        m_busy     = 1'b0;
        m_done_cyc = cyc;
        chk("rx_byte", {24'd0, rx_bits}, {24'd0, m_b});
      end
      if (!m_busy && dv && period != 0) begin
        m_busy  = 1'b1;
        m_k     = cyc;
        m_p     = int'(period);
        m_b     = tx_byte;
        rx_bits = 8'h00;
      end
    end
    @(negedge clk);
    chk("active", {31'd0, active}, {31'd0, m_busy});
    chk("line", {31'd0, line}, m_busy ? {31'd0, frame_bit(m_b, (cyc - m_k) / m_p)} : 32'd1);
    chk("done", {31'd0, done}, (m_done_cyc == cyc) ? 32'd1 : 32'd0);
    if (m_busy) begin
      off = cyc - m_k;
      idx = off / m_p;
      if ((off % m_p) == (m_p / 2) && idx >= 1 && idx <= 8) rx_bits[idx-1] = line;
    end
  endtask

  task automatic send(input int p, input logic [7:0] b);
    period  = 20'(p);
    tx_byte = b;
    dv      = 1'b1;
    tick();
    dv      = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int a;
    int b2;
    bit seen;
    rst = 1'b1; dv = 1'b0; period = 20'd4; tx_byte = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // P=4, 0xA3
    send(4, 8'hA3); a = cyc;
    wait_done(FRAME * 4 + 10, seen);
    chk("a3_frame_len", seen ? cyc - a : -1, FRAME * 4);
    repeat (2) tick();

    // P=217, 0x55
    send(217, 8'h55); a = cyc;
    wait_done(FRAME * 217 + 20, seen);
    chk("p217_frame_len", seen ? cyc - a : -1, FRAME * 217);
    repeat (2) tick();

    // back-to-back at P=3 with an ignored mid-frame request
    send(3, 8'h01); a = cyc;
    repeat (9) tick();
    send(3, 8'h5A);
    repeat (FRAME * 3 - 11) tick();
    send(3, 8'hFF); b2 = cyc;
    chk("b2b_gap", b2 - a, FRAME * 3);
    chk("b2b_done", {31'd0, done}, 1);
    chk("b2b_start", {30'd0, active, line}, 32'd2);
    wait_done(FRAME * 3 + 10, seen);
    chk("b2b_second_len", seen ? cyc - b2 : -1, FRAME * 3);
    repeat (2) tick();

    // period change mid-frame
    send(8, 8'hC4); a = cyc;
    repeat (3 * 8) tick();
    period = 20'd2;
    wait_done(FRAME * 8 + 10, seen);
    chk("latched_len", seen ? cyc - a : -1, FRAME * 8);
    send(2, 8'h3C); a = cyc;
    wait_done(FRAME * 2 + 10, seen);
    chk("new_period_len", seen ? cyc - a : -1, FRAME * 2);
    repeat (2) tick();

    // asynchronous reset in the middle of data bit 5
    send(4, 8'h96);
    repeat (5 * 4 + 1) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", {31'd0, line}, 1);
    chk("async_rst_active", {31'd0, active}, 0);
    chk("async_rst_done", {31'd0, done}, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    send(4, 8'h5B); a = cyc;
    wait_done(FRAME * 4 + 10, seen);
    chk("post_rst_len", seen ? cyc - a : -1, FRAME * 4);

    // period 0 request is dropped
    send(0, 8'hFF);
    repeat (6) tick();
    chk("p0_active", {31'd0, active}, 0);

    // minimum period
    send(1, 8'h81); a = cyc;
    wait_done(FRAME + 10, seen);
    chk("p1_len", seen ? cyc - a : -1, FRAME);
    repeat (2) tick();

`ifdef UART_TX_PARITY_EN
    send(2, 8'h07); a = cyc;
    repeat (18) tick();
    chk("parity_bit", {31'd0, line}, 1);
    wait_done(FRAME * 2 + 10, seen);
    chk("parity_len", seen ? cyc - a : -1, 22);
    repeat (2) tick();
`endif

    // random requests, periods (including 0) and bytes at random times
    for (int i = 0; i < 800; i++) begin
      dv      = ($urandom_range(0, 7) == 0);
      period  = 20'($urandom_range(0, 5));
      tx_byte = 8'($urandom);
      tick();
    end
    dv = 1'b0;
    repeat (80) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
